// File: rtl/memory_game_pkg.sv
// Shared types and constants for the 4x4 memory (pairs) game.
// Imported by the turn sequencer and its cursor helper.
package memory_game_pkg;

    localparam int N_CELLS = 16;
    localparam int N_PAIRS = 8;
    localparam int CARD_W  = 3;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PICK1     = 3'd1,
        ST_PICK2     = 3'd2,
        ST_COMPARE   = 3'd3,
        ST_SHOW_MISS = 3'd4,
        ST_DONE      = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        CELL_HIDDEN   = 2'd0,
        CELL_REVEALED = 2'd1,
        CELL_MATCHED  = 2'd2
    } cell_e;

    // Card id stored for one cell of a flattened deck.
    function automatic logic [CARD_W-1:0] card_at(
        input logic [N_CELLS*CARD_W-1:0] deck,
        input logic [3:0]                idx
    );
        return deck[idx*CARD_W +: CARD_W];
    endfunction

endpackage

// File: rtl/memory_turn_ctrl_next_cell_finder.sv
// Finds the first non-matched cell after the cursor, wrapping 15->0.
// Rotates the free mask so cursor+1 lands at bit 0, then priority-encodes.
module next_cell_finder
    import memory_game_pkg::*;
(
    input  logic [3:0]         cur,
    input  logic [N_CELLS-1:0] matched,
    output logic [3:0]         nxt,
    output logic               found
);

    logic [2*N_CELLS-2:0] free_dbl;
    logic [N_CELLS-2:0]   rot;
    logic [4:0]           offs;

    // Rotate the free mask and pick the lowest set bit (cursor itself excluded).
    always_comb begin
        free_dbl = {~matched[N_CELLS-2:0], ~matched};
        offs     = {1'b0, cur} + 5'd1;
        rot      = free_dbl[offs +: (N_CELLS-1)];
        nxt      = cur;
        found    = 1'b0;
        for (int j = N_CELLS-2; j >= 0; j--) begin
            if (rot[j]) begin
                nxt   = cur + 4'(j + 1);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/memory_turn_ctrl.sv
// Turn sequencer for the 4x4 memory game: board, cursor, player, scores.
// Consumes one-cycle move/select pulses; drives renderer and 7-seg.
module memory_turn_ctrl
    import memory_game_pkg::*;
#(
    parameter int unsigned SHOW_CYCLES = 50_000_000,
    parameter int unsigned TURN_CYCLES = 750_000_000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      move,
    input  logic                      select,
    input  logic [N_CELLS*CARD_W-1:0] deck,
    output logic [3:0]                cursor,
    output logic [2*N_CELLS-1:0]      cell_state,
    output logic                      player,
    output logic [3:0]                score0,
    output logic [3:0]                score1,
    output logic [2:0]                fsm_state,
    output logic                      game_over,
    output logic [1:0]                winner
);

    state_e                    state_q, state_d;
    logic [3:0]                cursor_q, cursor_d;
    logic [3:0]                first_q, first_d;
    logic [3:0]                second_q, second_d;
    logic [N_CELLS-1:0][1:0]   cells_q, cells_d;
    logic                      player_q, player_d;
    logic [3:0]                score0_q, score0_d;
    logic [3:0]                score1_q, score1_d;
    logic [31:0]               turn_tmr_q, turn_tmr_d;
    logic [31:0]               show_tmr_q, show_tmr_d;
    logic [N_CELLS*CARD_W-1:0] deck_q, deck_d;

    logic [N_CELLS-1:0]        matched;
    logic [3:0]                next_idx;
    logic                      next_found;
    logic                      ids_equal;
    logic [4:0]                pair_sum;

    localparam logic [31:0] TURN_LOAD = 32'(TURN_CYCLES - 1);
    localparam logic [31:0] SHOW_LOAD = 32'(SHOW_CYCLES - 1);

    // Matched mask for the cursor search, and compare-stage helpers.
    always_comb begin
        for (int i = 0; i < N_CELLS; i++) begin
            matched[i] = (cells_q[i] == CELL_MATCHED);
        end
        ids_equal = card_at(deck_q, first_q) == card_at(deck_q, second_q);
        pair_sum  = 5'(score0_q) + 5'(score1_q) + 5'd1;
    end

    next_cell_finder u_finder (
        .cur     (cursor_q),
        .matched (matched),
        .nxt     (next_idx),
        .found   (next_found)
    );

    // Next-state logic; timer expiry outranks select, select outranks move.
    always_comb begin
        state_d    = state_q;
        cursor_d   = cursor_q;
        first_d    = first_q;
        second_d   = second_q;
        cells_d    = cells_q;
        player_d   = player_q;
        score0_d   = score0_q;
        score1_d   = score1_q;
        turn_tmr_d = turn_tmr_q;
        show_tmr_d = show_tmr_q;
        deck_d     = deck_q;
        unique case (state_q)
            ST_IDLE: begin
                if (select) begin
                    deck_d     = deck;
                    cells_d    = '0;
                    cursor_d   = 4'd0;
                    player_d   = 1'b0;
                    score0_d   = 4'd0;
                    score1_d   = 4'd0;
                    turn_tmr_d = TURN_LOAD;
                    state_d    = ST_PICK1;
                end
            end
            ST_PICK1, ST_PICK2: begin
                if (turn_tmr_q == 32'd0) begin
                    for (int i = 0; i < N_CELLS; i++) begin
                        if (cells_q[i] == CELL_REVEALED) begin
                            cells_d[i] = CELL_HIDDEN;
                        end
                    end
                    player_d   = ~player_q;
                    turn_tmr_d = TURN_LOAD;
                    state_d    = ST_PICK1;
                end else begin
                    turn_tmr_d = turn_tmr_q - 32'd1;
                    if (select) begin
                        if (cells_q[cursor_q] == CELL_HIDDEN) begin
                            cells_d[cursor_q] = CELL_REVEALED;
                            if (state_q == ST_PICK1) begin
                                first_d = cursor_q;
                                state_d = ST_PICK2;
                            end else begin
                                second_d = cursor_q;
                                state_d  = ST_COMPARE;
                            end
                        end
                    end else if (move && next_found) begin
                        cursor_d = next_idx;
                    end
                end
            end
            ST_COMPARE: begin
                if (ids_equal) begin
                    cells_d[first_q]  = CELL_MATCHED;
                    cells_d[second_q] = CELL_MATCHED;
                    if (player_q) begin
                        score1_d = score1_q + 4'd1;
                    end else begin
                        score0_d = score0_q + 4'd1;
                    end
                    if (pair_sum == 5'(N_PAIRS)) begin
                        state_d = ST_DONE;
                    end else begin
                        turn_tmr_d = TURN_LOAD;
                        state_d    = ST_PICK1;
                    end
                end else begin
                    show_tmr_d = SHOW_LOAD;
                    state_d    = ST_SHOW_MISS;
                end
            end
            ST_SHOW_MISS: begin
                if (show_tmr_q == 32'd0) begin
                    cells_d[first_q]  = CELL_HIDDEN;
                    cells_d[second_q] = CELL_HIDDEN;
                    player_d          = ~player_q;
                    turn_tmr_d        = TURN_LOAD;
                    state_d           = ST_PICK1;
                end else begin
                    show_tmr_d = show_tmr_q - 32'd1;
                end
            end
            ST_DONE: begin
                if (select) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cursor_q   <= 4'd0;
            first_q    <= 4'd0;
            second_q   <= 4'd0;
            cells_q    <= '0;
            player_q   <= 1'b0;
            score0_q   <= 4'd0;
            score1_q   <= 4'd0;
            turn_tmr_q <= 32'd0;
            show_tmr_q <= 32'd0;
            deck_q     <= '0;
        end else begin
            state_q    <= state_d;
            cursor_q   <= cursor_d;
            first_q    <= first_d;
            second_q   <= second_d;
            cells_q    <= cells_d;
            player_q   <= player_d;
            score0_q   <= score0_d;
            score1_q   <= score1_d;
            turn_tmr_q <= turn_tmr_d;
            show_tmr_q <= show_tmr_d;
            deck_q     <= deck_d;
        end
    end

    // Output decode; winner is only meaningful while the game is over.
    always_comb begin
        cursor     = cursor_q;
        cell_state = cells_q;
        player     = player_q;
        score0     = score0_q;
        score1     = score1_q;
        fsm_state  = state_q;
        game_over  = (state_q == ST_DONE);
        winner     = 2'd0;
        if (game_over) begin
            if (score0_q > score1_q) begin
                winner = 2'd1;
            end else if (score1_q > score0_q) begin
                winner = 2'd2;
            end else begin
                winner = 2'd3;
            end
        end
    end

endmodule
